imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_pkg.sv | 18 +
 rtl/imem_arb_starve_cnt.sv | 28 ++
 rtl/imem_arbiter.sv | 140 ++++++++++++++
 tb/tb_imem_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// rtl/imem_arbiter_pkg.sv - shared encodings and constants for the instruction memory arbiter
package imem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_FETCH  = 2'd1,
        OWN_LOADER = 2'd2
    } owner_e;

    localparam logic [31:0] NOP_INST = 32'h00000013;

endpackage

// File: rtl/imem_arb_starve_cnt.sv
// rtl/imem_arb_starve_cnt.sv - saturating wait counter flagging a starved loader
module imem_arb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic full
);

    localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != W'(LIMIT))) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign full = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - fetch/loader arbiter onto one memory port; IMEM_ARBITER_RANGE_CHECK_EN adds address range check
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int INST_WIDTH   = 32,
    parameter int IMEM_DEPTH   = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [INST_WIDTH-1:0] f_rdata,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic [ADDR_WIDTH-1:0] l_addr,
    input  logic [INST_WIDTH-1:0] l_wdata,
    output logic                  l_gnt,
    output logic                  l_rvalid,
    output logic [INST_WIDTH-1:0] l_rdata,
    input  logic                  load_done,
    input  logic                  reload_req,
    output logic                  m_en,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [INST_WIDTH-1:0] m_wdata,
    input  logic [INST_WIDTH-1:0] m_rdata,
    output logic [1:0]            state_o,
    output logic                  err
);

`ifdef IMEM_ARBITER_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    arb_state_e state_q, state_d;
    owner_e     owner_q, owner_d;

    logic                  starve_full;
    logic                  any_gnt;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  oor;
    logic [INST_WIDTH-1:0] rdata_src;

    always_comb begin
        state_d = state_q;
        f_gnt   = 1'b0;
        l_gnt   = 1'b0;
        case (state_q)
            ST_BOOT: begin
                l_gnt = l_req;
                if (load_done) state_d = ST_RUN;
            end
            ST_RUN: begin
                // a starved loader overrides fetch priority for exactly one grant
                if (starve_full && l_req) begin
                    l_gnt = 1'b1;
                end else begin
                    f_gnt = f_req;
                    l_gnt = l_req & ~f_req;
                end
                if (reload_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (owner_q == OWN_NONE) state_d = ST_BOOT;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    imem_arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((state_q == ST_RUN) && l_req && !l_gnt),
        .clr   ((state_q != ST_RUN) || l_gnt),
        .full  (starve_full)
    );

    assign any_gnt  = f_gnt | l_gnt;
    assign sel_we   = l_gnt & l_we;
    assign sel_addr = l_gnt ? l_addr : f_addr;
    assign oor      = RANGE_CHECK && any_gnt && (sel_addr >= ADDR_WIDTH'(IMEM_DEPTH));

    assign m_en    = any_gnt & ~oor;
    assign m_we    = sel_we & ~oor;
    assign m_addr  = sel_addr;
    assign m_wdata = l_gnt ? l_wdata : '0;

    always_comb begin
        owner_d = OWN_NONE;
        if (any_gnt && !sel_we) owner_d = f_gnt ? OWN_FETCH : OWN_LOADER;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

`ifdef IMEM_ARBITER_RANGE_CHECK_EN
    logic err_q;
    logic nop_q;

    // rejected reads still complete, returning a NOP instead of memory data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            nop_q <= 1'b0;
        end else begin
            err_q <= oor;
            nop_q <= oor & ~sel_we;
        end
    end

    assign err       = err_q;
    assign rdata_src = nop_q ? INST_WIDTH'(NOP_INST) : m_rdata;
`else
    assign err       = 1'b0;
    assign rdata_src = m_rdata;
`endif

    assign f_rvalid = (owner_q == OWN_FETCH);
    assign l_rvalid = (owner_q == OWN_LOADER);
    assign f_rdata  = f_rvalid ? rdata_src : '0;
    assign l_rdata  = l_rvalid ? rdata_src : '0;
    assign state_o  = state_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, f_gnt, f_rvalid;
    logic [31:0] f_addr, f_rdata;
    logic        l_req, l_we, l_gnt, l_rvalid;
    logic [31:0] l_addr, l_wdata, l_rdata;
    logic        load_done, reload_req;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = 32'h0;
    logic [1:0]  state_o;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:1023];
    logic [9:0]  mem_idx;

    always #5 clk = ~clk;

    imem_arbiter #(
        .ADDR_WIDTH   (32),
        .INST_WIDTH   (32),
        .IMEM_DEPTH   (1024),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_gnt      (f_gnt),
        .f_rvalid   (f_rvalid),
        .f_rdata    (f_rdata),
        .l_req      (l_req),
        .l_we       (l_we),
        .l_addr     (l_addr),
        .l_wdata    (l_wdata),
        .l_gnt      (l_gnt),
        .l_rvalid   (l_rvalid),
        .l_rdata    (l_rdata),
        .load_done  (load_done),
        .reload_req (reload_req),
        .m_en       (m_en),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .state_o    (state_o),
        .err        (err)
    );

    // word-addressed behavioural memory with one-cycle read latency
    assign mem_idx = m_addr[11:2];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[mem_idx] <= m_wdata;
            else      m_rdata <= mem[mem_idx];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[1] = 32'hDEADBEEF;
        rst_n = 1'b0; f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0;
        l_wdata = 0; load_done = 0; reload_req = 0;

        @(negedge clk);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_f_rvalid", 32'(f_rvalid), 32'd0);
        check("rst_l_rvalid", 32'(l_rvalid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_m_en", 32'(m_en), 32'd0);

        // boot: loader write with load_done in the same cycle, fetch locked out
        next_cycle();
        rst_n = 1'b1;
        l_req = 1; l_we = 1; l_addr = 0; l_wdata = 32'h003100B3; load_done = 1; f_req = 1;
        @(negedge clk);
        check("boot_l_gnt", 32'(l_gnt), 32'd1);
        check("boot_f_gnt", 32'(f_gnt), 32'd0);
        check("boot_m_en", 32'(m_en), 32'd1);
        check("boot_m_we", 32'(m_we), 32'd1);
        check("boot_m_addr", m_addr, 32'd0);
        check("boot_m_wdata", m_wdata, 32'h003100B3);
        check("boot_state", 32'(state_o), 32'd0);

        next_cycle();
        l_req = 0; l_we = 0; load_done = 0; f_req = 1; f_addr = 0;
        @(negedge clk);
        check("run_state", 32'(state_o), 32'd1);
        check("run_f_gnt", 32'(f_gnt), 32'd1);
        check("run_m_we", 32'(m_we), 32'd0);
        check("run_l_rvalid_wr", 32'(l_rvalid), 32'd0);

        next_cycle();
        f_req = 0;
        @(negedge clk);
        check("fetch_rvalid", 32'(f_rvalid), 32'd1);
        check("fetch_rdata", f_rdata, 32'h003100B3);
        check("fetch_l_rvalid", 32'(l_rvalid), 32'd0);
        check("fetch_l_rdata", l_rdata, 32'd0);
        check("idle_m_en", 32'(m_en), 32'd0);

        // starvation: loader wins every 5th cycle with both requesting
        next_cycle();
        f_req = 1; f_addr = 0; l_req = 1; l_we = 0; l_addr = 32'd4;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("starve_l_gnt_%0d", i), 32'(l_gnt), (i % 5 == 4) ? 32'd1 : 32'd0);
            check($sformatf("starve_f_gnt_%0d", i), 32'(f_gnt), (i % 5 == 4) ? 32'd0 : 32'd1);
            if (i == 5) begin
                check("starve_l_rvalid", 32'(l_rvalid), 32'd1);
                check("starve_l_rdata", l_rdata, 32'hDEADBEEF);
                check("starve_f_rvalid", 32'(f_rvalid), 32'd0);
            end
            next_cycle();
        end

        // read then reload: data still delivered, RUN -> DRAIN -> BOOT
        f_req = 1; f_addr = 32'd4; l_req = 0;
        @(negedge clk);
        check("drain_rd_gnt", 32'(f_gnt), 32'd1);
        next_cycle();
        f_req = 0; reload_req = 1;
        @(negedge clk);
        check("drain_rvalid", 32'(f_rvalid), 32'd1);
        check("drain_rdata", f_rdata, 32'hDEADBEEF);
        check("drain_pre_state", 32'(state_o), 32'd1);
        next_cycle();
        reload_req = 0; f_req = 1; l_req = 1; l_we = 0; l_addr = 32'd4;
        @(negedge clk);
        check("drain_state", 32'(state_o), 32'd2);
        check("drain_f_gnt", 32'(f_gnt), 32'd0);
        check("drain_l_gnt", 32'(l_gnt), 32'd0);
        check("drain_m_en", 32'(m_en), 32'd0);
        next_cycle();
        @(negedge clk);
        check("reboot_state", 32'(state_o), 32'd0);
        check("reboot_f_gnt", 32'(f_gnt), 32'd0);
        check("reboot_l_gnt", 32'(l_gnt), 32'd1);

        // reload_req is ignored while booting
        next_cycle();
        f_req = 0; l_req = 0; reload_req = 1;
        next_cycle();
        reload_req = 0;
        @(negedge clk);
        check("boot_ignore_reload", 32'(state_o), 32'd0);
        load_done = 1;
        next_cycle();
        load_done = 0;
        @(negedge clk);
        check("rerun_state", 32'(state_o), 32'd1);

        // out-of-range fetch
        next_cycle();
        f_req = 1; f_addr = 32'd4096;
        @(negedge clk);
        check("oor_f_gnt", 32'(f_gnt), 32'd1);
`ifdef IMEM_ARBITER_RANGE_CHECK_EN
        check("oor_m_en", 32'(m_en), 32'd0);
        next_cycle();
        f_req = 0;
        @(negedge clk);
        check("oor_rvalid", 32'(f_rvalid), 32'd1);
        check("oor_rdata", f_rdata, 32'h00000013);
        check("oor_err", 32'(err), 32'd1);
        next_cycle();
        @(negedge clk);
        check("oor_err_clear", 32'(err), 32'd0);
`else
        check("oor_m_en", 32'(m_en), 32'd1);
        check("oor_m_addr", m_addr, 32'd4096);
        next_cycle();
        f_req = 0;
        @(negedge clk);
        check("oor_rvalid", 32'(f_rvalid), 32'd1);
        check("oor_err", 32'(err), 32'd0);
`endif

        // reset with a read outstanding discards it
        next_cycle();
        f_req = 1; f_addr = 0;
        @(negedge clk);
        check("rst_rd_gnt", 32'(f_gnt), 32'd1);
        next_cycle();
        f_req = 0; rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_rvalid", 32'(f_rvalid), 32'd0);
        check("rst_mid_state", 32'(state_o), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_post_rvalid", 32'(f_rvalid), 32'd0);
        check("rst_post_state", 32'(state_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
